gelato_inst_buffer: RTL

- Per-warp instruction buffer between the instruction fetch/decode stage and the issue stage.
- Holds up to DEPTH decoded instructions for each warp in a private FIFO.
- Presents one ready instruction per cycle to issue, selected by round-robin arbitration across non-empty warps.
- Exports a per-warp full mask so the PC table stops selecting warps whose buffer is full; supports per-warp flush on control-flow redirect.

---
 rtl/gelato_inst_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer: one small FIFO per warp feeding issue through a
// round-robin selector, with per-warp flush on control-flow redirect.
module gelato_inst_buffer #(
  parameter int NUM_WARPS     = 4,
  parameter int WARP_ID_WIDTH = 2,
  parameter int DEPTH         = 2,
  parameter int INST_WIDTH    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     in_valid,
  input  logic [WARP_ID_WIDTH-1:0] in_warp_id,
  input  logic [INST_WIDTH-1:0]    in_inst,
  output logic                     in_ready,
  output logic [NUM_WARPS-1:0]     full_mask,
  output logic                     out_valid,
  output logic [WARP_ID_WIDTH-1:0] out_warp_id,
  output logic [INST_WIDTH-1:0]    out_inst,
  input  logic                     out_ready,
  input  logic                     flush_valid,
  input  logic [WARP_ID_WIDTH-1:0] flush_warp_id
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = WARP_ID_WIDTH + 1;

  logic [CNT_W-1:0]         count_q  [NUM_WARPS];
  logic [CNT_W-1:0]         count_d  [NUM_WARPS];
  logic [PTR_W-1:0]         rd_ptr_q [NUM_WARPS];
  logic [PTR_W-1:0]         rd_ptr_d [NUM_WARPS];
  logic [PTR_W-1:0]         wr_ptr_q [NUM_WARPS];
  logic [PTR_W-1:0]         wr_ptr_d [NUM_WARPS];
  logic [WARP_ID_WIDTH-1:0] rr_ptr_q;
  logic [WARP_ID_WIDTH-1:0] rr_ptr_d;
  logic [INST_WIDTH-1:0]    mem_q    [NUM_WARPS][DEPTH];
  logic [INST_WIDTH-1:0]    mem_d    [NUM_WARPS][DEPTH];

  logic [NUM_WARPS-1:0]     full_s;
  logic [NUM_WARPS-1:0]     cand_s;
  logic [NUM_WARPS-1:0]     push_w_s;
  logic [NUM_WARPS-1:0]     pop_w_s;
  logic                     in_ready_s;
  logic                     out_valid_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     flush_s;
  logic                     found_s;
  logic [WARP_ID_WIDTH-1:0] sel_s;
  logic [SUM_W-1:0]         arb_sum_s;
  logic [WARP_ID_WIDTH-1:0] arb_idx_s;

  // Per-warp status from registered counts; a flushed warp is never a candidate
  always_comb begin
    full_s = {NUM_WARPS{1'b0}};
    cand_s = {NUM_WARPS{1'b0}};
    for (int w = 0; w < NUM_WARPS; w++) begin
      full_s[w] = (count_q[w] == CNT_W'(DEPTH));
      cand_s[w] = (count_q[w] != {CNT_W{1'b0}}) &&
                  !(flush_valid && (flush_warp_id == WARP_ID_WIDTH'(w)));
    end
    in_ready_s = rdy && !full_s[in_warp_id] &&
                 !(flush_valid && (flush_warp_id == in_warp_id));
  end

  // Round-robin search starting at rr_ptr, first candidate wins
  always_comb begin
    found_s   = 1'b0;
    sel_s     = {WARP_ID_WIDTH{1'b0}};
    arb_sum_s = {SUM_W{1'b0}};
    arb_idx_s = {WARP_ID_WIDTH{1'b0}};
    for (int i = 0; i < NUM_WARPS; i++) begin
      arb_sum_s = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (arb_sum_s >= SUM_W'(NUM_WARPS)) begin
        arb_sum_s = arb_sum_s - SUM_W'(NUM_WARPS);
      end else begin
        arb_sum_s = arb_sum_s;
      end
      arb_idx_s = arb_sum_s[WARP_ID_WIDTH-1:0];
      if (!found_s && cand_s[arb_idx_s]) begin
        found_s = 1'b1;
        sel_s   = arb_idx_s;
      end else begin
        found_s = found_s;
      end
    end
    out_valid_s = found_s && rdy;
  end

  // Next-state: flush wins over push/pop on its warp; rdy low freezes everything
  always_comb begin
    push_s   = in_valid && in_ready_s;
    pop_s    = out_valid_s && out_ready;
    flush_s  = flush_valid && rdy;
    push_w_s = {NUM_WARPS{1'b0}};
    pop_w_s  = {NUM_WARPS{1'b0}};
    mem_d    = mem_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_w_s[w] = push_s && (in_warp_id == WARP_ID_WIDTH'(w));
      pop_w_s[w]  = pop_s && (sel_s == WARP_ID_WIDTH'(w));
      count_d[w]  = count_q[w];
      rd_ptr_d[w] = rd_ptr_q[w];
      wr_ptr_d[w] = wr_ptr_q[w];
      if (flush_s && (flush_warp_id == WARP_ID_WIDTH'(w))) begin
        count_d[w]  = {CNT_W{1'b0}};
        rd_ptr_d[w] = {PTR_W{1'b0}};
        wr_ptr_d[w] = {PTR_W{1'b0}};
      end else begin
        if (push_w_s[w]) begin
          wr_ptr_d[w] = wr_ptr_q[w] + PTR_W'(1);
        end else begin
          wr_ptr_d[w] = wr_ptr_q[w];
        end
        if (pop_w_s[w]) begin
          rd_ptr_d[w] = rd_ptr_q[w] + PTR_W'(1);
        end else begin
          rd_ptr_d[w] = rd_ptr_q[w];
        end
        case ({push_w_s[w], pop_w_s[w]})
          2'b10:   count_d[w] = count_q[w] + CNT_W'(1);
          2'b01:   count_d[w] = count_q[w] - CNT_W'(1);
          default: count_d[w] = count_q[w];
        endcase
      end
    end
    if (push_s) begin
      mem_d[in_warp_id][wr_ptr_q[in_warp_id]] = in_inst;
    end else begin
      mem_d = mem_q;
    end
    if (pop_s) begin
      rr_ptr_d = (sel_s == WARP_ID_WIDTH'(NUM_WARPS - 1)) ? {WARP_ID_WIDTH{1'b0}}
                                                          : sel_s + WARP_ID_WIDTH'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Control state: counts, pointers and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count_q[w]  <= {CNT_W{1'b0}};
        rd_ptr_q[w] <= {PTR_W{1'b0}};
        wr_ptr_q[w] <= {PTR_W{1'b0}};
      end
      rr_ptr_q <= {WARP_ID_WIDTH{1'b0}};
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count_q[w]  <= count_d[w];
        rd_ptr_q[w] <= rd_ptr_d[w];
        wr_ptr_q[w] <= wr_ptr_d[w];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the counts
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready    = in_ready_s;
  assign full_mask   = full_s;
  assign out_valid   = out_valid_s;
  assign out_warp_id = sel_s;
  assign out_inst    = mem_q[sel_s][rd_ptr_q[sel_s]];

endmodule
